// File: rtl/vxe_axi_switch_arb_if.sv
// Client-side and upstream-side request/data handshake bundle for vxe_axi_switch_arb.
// slave = arbiter view, master = the driving environment view.
interface vxe_axi_switch_arb_if #(
  parameter int unsigned NCLI = 4
);
  localparam int unsigned AW = 44;
  localparam int unsigned DW = 72;

  logic [NCLI-1:0]    i_c_rqa_vld;
  logic [NCLI*AW-1:0] i_c_rqa;
  logic [NCLI-1:0]    o_c_rqa_rd;
  logic [NCLI-1:0]    i_c_rqd_vld;
  logic [NCLI*DW-1:0] i_c_rqd;
  logic [NCLI-1:0]    o_c_rqd_rd;
  logic               o_m_rqa_vld;
  logic [AW-1:0]      o_m_rqa;
  logic               i_m_rqa_rd;
  logic               o_m_rqd_vld;
  logic [DW-1:0]      o_m_rqd;
  logic               i_m_rqd_rd;

  modport slave (
    input  i_c_rqa_vld, i_c_rqa, i_c_rqd_vld, i_c_rqd, i_m_rqa_rd, i_m_rqd_rd,
    output o_c_rqa_rd, o_c_rqd_rd, o_m_rqa_vld, o_m_rqa, o_m_rqd_vld, o_m_rqd
  );

  modport master (
    output i_c_rqa_vld, i_c_rqa, i_c_rqd_vld, i_c_rqd, i_m_rqa_rd, i_m_rqd_rd,
    input  o_c_rqa_rd, o_c_rqd_rd, o_m_rqa_vld, o_m_rqa, o_m_rqd_vld, o_m_rqd
  );
endinterface

// File: rtl/vxe_axi_switch_arb.sv
// Round-robin arbiter merging NCLI client rqa/rqd streams into one registered upstream stage.
// Optional client-0 priority with starvation guard: define VXE_AXI_SWITCH_ARB_QOS_EN.
module vxe_axi_switch_arb #(
  parameter int unsigned NCLI       = 4,
  parameter int unsigned STARVE_LIM = 8
) (
  input  logic                 clk,
  input  logic                 nrst,
  vxe_axi_switch_arb_if.slave  bus
);
  localparam int unsigned AW      = 44;
  localparam int unsigned DW      = 72;
  localparam int unsigned PW      = (NCLI > 1) ? $clog2(NCLI) : 1;
  localparam int unsigned RNW_BIT = 43;

  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            m_rqa_vld_q, m_rqd_vld_q;
  logic [AW-1:0]   m_rqa_q;
  logic [DW-1:0]   m_rqd_q;

  logic [NCLI-1:0] elig_c;
  logic            stage_free_c;
  logic            gnt_vld_c;
  logic            gnt_wr_c;
  logic [PW-1:0]   gnt_idx_c;
  logic [AW-1:0]   gnt_rqa_c;
  logic [DW-1:0]   gnt_rqd_c;
  logic [NCLI-1:0] rqa_rd_c, rqd_rd_c;

`ifdef VXE_AXI_SWITCH_ARB_QOS_EN
  logic [3:0]      starve_q;
  logic            others_c;
`else
  logic            unused_starve_lim;
  assign unused_starve_lim = ^32'(STARVE_LIM);
`endif

  // Request decode: rnw lives in the top address bit; writes need their data beat present.
  always_comb begin
    elig_c = '0;
    for (int unsigned k = 0; k < NCLI; k++) begin
      elig_c[k] = bus.i_c_rqa_vld[k] &&
                  (bus.i_c_rqa[k*AW + RNW_BIT] || bus.i_c_rqd_vld[k]);
    end
  end

  // Grant selection, payload mux and pointer advance.
  always_comb begin
    logic [PW-1:0]   idx_p;
    int unsigned     idx;
    idx          = 0;
    idx_p        = '0;
    gnt_vld_c    = 1'b0;
    gnt_idx_c    = '0;
    gnt_rqa_c    = '0;
    gnt_rqd_c    = '0;
    gnt_wr_c     = 1'b0;
    rqa_rd_c     = '0;
    rqd_rd_c     = '0;
    stage_free_c = (!m_rqa_vld_q || bus.i_m_rqa_rd) && (!m_rqd_vld_q || bus.i_m_rqd_rd);
`ifdef VXE_AXI_SWITCH_ARB_QOS_EN
    others_c = |elig_c[NCLI-1:1];
`endif

    for (int unsigned off = 0; off < NCLI; off++) begin
      idx   = (32'(rr_ptr_q) + off) % NCLI;
      idx_p = PW'(idx);
`ifdef VXE_AXI_SWITCH_ARB_QOS_EN
      if (!gnt_vld_c && elig_c[idx_p] && (idx_p != '0)) begin
`else
      if (!gnt_vld_c && elig_c[idx_p]) begin
`endif
        gnt_vld_c = 1'b1;
        gnt_idx_c = idx_p;
      end
    end

`ifdef VXE_AXI_SWITCH_ARB_QOS_EN
    // Client 0 wins unless the others have waited out a full starvation window.
    if (elig_c[0] && !(others_c && (starve_q == 4'(STARVE_LIM)))) begin
      gnt_vld_c = 1'b1;
      gnt_idx_c = '0;
    end
`endif

    if (!nrst || !stage_free_c) begin
      gnt_vld_c = 1'b0;
    end

    for (int unsigned k = 0; k < NCLI; k++) begin
      if (gnt_idx_c == PW'(k)) begin
        gnt_rqa_c = bus.i_c_rqa[k*AW +: AW];
        gnt_rqd_c = bus.i_c_rqd[k*DW +: DW];
        gnt_wr_c  = !bus.i_c_rqa[k*AW + RNW_BIT];
      end
    end

    if (gnt_vld_c) begin
      rqa_rd_c[gnt_idx_c] = 1'b1;
      rqd_rd_c[gnt_idx_c] = gnt_wr_c;
    end

    rr_ptr_d = rr_ptr_q;
    if (gnt_vld_c) begin
      rr_ptr_d = (gnt_idx_c == PW'(NCLI - 1)) ? '0 : gnt_idx_c + PW'(1);
    end
  end

  // Output stage: address and data of a write are loaded together to keep AW/W paired.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rr_ptr_q    <= '0;
      m_rqa_vld_q <= 1'b0;
      m_rqd_vld_q <= 1'b0;
      m_rqa_q     <= '0;
      m_rqd_q     <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (gnt_vld_c) begin
        m_rqa_q     <= gnt_rqa_c;
        m_rqa_vld_q <= 1'b1;
        if (gnt_wr_c) begin
          m_rqd_q     <= gnt_rqd_c;
          m_rqd_vld_q <= 1'b1;
        end else begin
          m_rqd_vld_q <= m_rqd_vld_q && !bus.i_m_rqd_rd;
        end
      end else begin
        if (bus.i_m_rqa_rd) m_rqa_vld_q <= 1'b0;
        if (bus.i_m_rqd_rd) m_rqd_vld_q <= 1'b0;
      end
    end
  end

`ifdef VXE_AXI_SWITCH_ARB_QOS_EN
  // Consecutive client-0 grants while someone else is waiting.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      starve_q <= '0;
    end else if (!others_c) begin
      starve_q <= '0;
    end else if (gnt_vld_c) begin
      starve_q <= (gnt_idx_c == '0) ? starve_q + 4'd1 : 4'd0;
    end
  end
`endif

  assign bus.o_c_rqa_rd  = rqa_rd_c;
  assign bus.o_c_rqd_rd  = rqd_rd_c;
  assign bus.o_m_rqa_vld = m_rqa_vld_q;
  assign bus.o_m_rqa     = m_rqa_q;
  assign bus.o_m_rqd_vld = m_rqd_vld_q;
  assign bus.o_m_rqd     = m_rqd_q;

endmodule

// File: tb/tb_vxe_axi_switch_arb.sv
// Self-checking bench for vxe_axi_switch_arb: directed scenarios plus randomized traffic
// against a queue/array reference model of the arbitration rules.
module tb_vxe_axi_switch_arb;
  localparam int unsigned NCLI    = 4;
  localparam int unsigned AW      = 44;
  localparam int unsigned DW      = 72;
  localparam int unsigned RNW_BIT = 43;
`ifdef VXE_AXI_SWITCH_ARB_QOS_EN
  localparam int STARVE_LIM = 8;
`endif

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  vxe_axi_switch_arb_if #(.NCLI(NCLI)) bus ();
  vxe_axi_switch_arb #(.NCLI(NCLI)) dut (.clk(clk), .nrst(nrst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  // Client stimulus state
  bit            cl_av [NCLI];
  bit            cl_dv [NCLI];
  logic [AW-1:0] cl_a  [NCLI];
  logic [DW-1:0] cl_d  [NCLI];

  // Reference model: last-grant pointer, staged beat, starvation count, delivery streams
  int            m_ptr;
  int            m_starve;
  bit            m_a_vld, m_d_vld;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d;
  logic [AW-1:0] exp_a[$], act_a[$];
  logic [DW-1:0] exp_d[$], act_d[$];

  function automatic void drive();
    for (int k = 0; k < NCLI; k++) begin
      bus.i_c_rqa_vld[k]        = cl_av[k];
      bus.i_c_rqd_vld[k]        = cl_dv[k];
      bus.i_c_rqa[k*AW +: AW]   = cl_a[k];
      bus.i_c_rqd[k*DW +: DW]   = cl_d[k];
    end
  endfunction

  function automatic void put_cli(int k, bit av, bit rnw, bit dv);
    cl_av[k] = av;
    cl_dv[k] = dv;
    cl_a[k]  = 44'({$urandom(), $urandom()});
    cl_a[k][RNW_BIT] = rnw;
    cl_d[k]  = 72'({$urandom(), $urandom(), $urandom()});
    drive();
  endfunction

  function automatic void idle_all();
    for (int k = 0; k < NCLI; k++) put_cli(k, 1'b0, 1'b1, 1'b0);
  endfunction

  function automatic void set_up_rd(bit a, bit d);
    bus.i_m_rqa_rd = a;
    bus.i_m_rqd_rd = d;
  endfunction

  function automatic void model_reset();
    m_ptr = 0; m_starve = 0;
    m_a_vld = 1'b0; m_d_vld = 1'b0;
    m_a = '0; m_d = '0;
    exp_a.delete(); act_a.delete(); exp_d.delete(); act_d.delete();
  endfunction

  function automatic bit elig(int k);
    return cl_av[k] && (cl_a[k][RNW_BIT] || cl_dv[k]);
  endfunction

  function automatic bit others();
    bit o = 1'b0;
    for (int k = 1; k < NCLI; k++) o |= elig(k);
    return o;
  endfunction

  function automatic bit is_wr(int k);
    return !cl_a[k][RNW_BIT];
  endfunction

  // Which client the rules say should be accepted this cycle (-1 = none).
  function automatic int predict();
    bit free;
    int c;
    free = (!m_a_vld || bus.i_m_rqa_rd) && (!m_d_vld || bus.i_m_rqd_rd);
    if (nrst !== 1'b1 || !free) return -1;
`ifdef VXE_AXI_SWITCH_ARB_QOS_EN
    if (elig(0) && !(others() && m_starve == STARVE_LIM)) return 0;
    for (int i = 0; i < NCLI; i++) begin
      c = (m_ptr + i) % NCLI;
      if (c != 0 && elig(c)) return c;
    end
`else
    for (int i = 0; i < NCLI; i++) begin
      c = (m_ptr + i) % NCLI;
      if (elig(c)) return c;
    end
`endif
    return -1;
  endfunction

  function automatic logic [NCLI-1:0] onehot(int k);
    logic [NCLI-1:0] v = '0;
    if (k >= 0) v[k] = 1'b1;
    return v;
  endfunction

  // Advance one clock: record upstream deliveries, then update the model at the edge.
  task automatic tick();
    int w;
    bit oth;
    w   = predict();
    oth = others();
    if (bus.o_m_rqa_vld && bus.i_m_rqa_rd) act_a.push_back(bus.o_m_rqa);
    if (bus.o_m_rqd_vld && bus.i_m_rqd_rd) act_d.push_back(bus.o_m_rqd);
    @(posedge clk);
    if (w >= 0) begin
      m_a = cl_a[w]; m_a_vld = 1'b1; exp_a.push_back(cl_a[w]);
      if (is_wr(w)) begin
        m_d = cl_d[w]; m_d_vld = 1'b1; exp_d.push_back(cl_d[w]);
      end else begin
        m_d_vld = 1'b0;
      end
      m_ptr = (w + 1) % NCLI;
    end else begin
      if (bus.i_m_rqa_rd) m_a_vld = 1'b0;
      if (bus.i_m_rqd_rd) m_d_vld = 1'b0;
    end
    if (!oth) m_starve = 0;
    else if (w == 0) m_starve++;
    else if (w > 0) m_starve = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int k = 0; k < NCLI; k++) put_cli(k, 1'b1, 1'b1, 1'b0);
    @(negedge clk); @(negedge clk); #1;
    n_cmp++; if (bus.o_m_rqa_vld !== 1'b0) begin n_err++; $display("FAIL reset_rqa_vld: got %b expected 0", bus.o_m_rqa_vld); end
    n_cmp++; if (bus.o_m_rqd_vld !== 1'b0) begin n_err++; $display("FAIL reset_rqd_vld: got %b expected 0", bus.o_m_rqd_vld); end
    n_cmp++; if (bus.o_m_rqa !== '0) begin n_err++; $display("FAIL reset_rqa: got %h expected 0", bus.o_m_rqa); end
    n_cmp++; if (bus.o_m_rqd !== '0) begin n_err++; $display("FAIL reset_rqd: got %h expected 0", bus.o_m_rqd); end
    n_cmp++; if (bus.o_c_rqa_rd !== '0) begin n_err++; $display("FAIL reset_client_rd: got %b expected 0", bus.o_c_rqa_rd); end
    @(negedge clk);
    nrst = 1'b1;
    model_reset();
  endtask

  task automatic test_rr_reads();
    int exp_g[5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (bus.o_c_rqa_rd !== onehot(exp_g[i])) begin n_err++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, bus.o_c_rqa_rd, onehot(exp_g[i])); end
      n_cmp++; if (bus.o_c_rqd_rd !== '0) begin n_err++; $display("FAIL rr_rqd_rd[%0d]: got %b expected 0", i, bus.o_c_rqd_rd); end
      tick();
      #1;
      n_cmp++; if (bus.o_m_rqa_vld !== 1'b1 || bus.o_m_rqa !== cl_a[exp_g[i]]) begin n_err++; $display("FAIL rr_out[%0d]: got vld=%b %h expected vld=1 %h", i, bus.o_m_rqa_vld, bus.o_m_rqa, cl_a[exp_g[i]]); end
    end
  endtask

  task automatic test_write();
    logic [AW-1:0] sa;
    logic [DW-1:0] sd;
    idle_all();
    put_cli(2, 1'b1, 1'b0, 1'b1);
    cl_d[2] = 72'hFF_0123456789ABCDEF;
    drive();
    sa = cl_a[2]; sd = cl_d[2];
    #1;
    n_cmp++; if (bus.o_c_rqa_rd !== 4'b0100) begin n_err++; $display("FAIL wr_rqa_rd: got %b expected 0100", bus.o_c_rqa_rd); end
    n_cmp++; if (bus.o_c_rqd_rd !== 4'b0100) begin n_err++; $display("FAIL wr_rqd_rd: got %b expected 0100", bus.o_c_rqd_rd); end
    tick();
    idle_all();
    #1;
    n_cmp++; if (bus.o_m_rqa_vld !== 1'b1 || bus.o_m_rqa !== sa) begin n_err++; $display("FAIL wr_out_a: got vld=%b %h expected vld=1 %h", bus.o_m_rqa_vld, bus.o_m_rqa, sa); end
    n_cmp++; if (bus.o_m_rqd_vld !== 1'b1 || bus.o_m_rqd !== sd) begin n_err++; $display("FAIL wr_out_d: got vld=%b %h expected vld=1 %h", bus.o_m_rqd_vld, bus.o_m_rqd, sd); end
  endtask

  task automatic test_wait_data();
    logic [DW-1:0] sd;
    idle_all();
    put_cli(1, 1'b1, 1'b0, 1'b0);
    put_cli(3, 1'b1, 1'b1, 1'b0);
    put_cli(0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (bus.o_c_rqa_rd !== ((c == 0) ? 4'b1000 : 4'b0000)) begin n_err++; $display("FAIL wait_rqa_rd[%0d]: got %b expected %b", c, bus.o_c_rqa_rd, (c == 0) ? 4'b1000 : 4'b0000); end
      n_cmp++; if (bus.o_c_rqd_rd !== 4'b0000) begin n_err++; $display("FAIL wait_rqd_rd[%0d]: got %b expected 0000", c, bus.o_c_rqd_rd); end
      tick();
      if (c == 0) begin cl_av[3] = 1'b0; drive(); end
    end
    cl_dv[1] = 1'b1; drive();
    sd = cl_d[1];
    #1;
    n_cmp++; if (bus.o_c_rqa_rd !== 4'b0010 || bus.o_c_rqd_rd !== 4'b0010) begin n_err++; $display("FAIL wait_grant1: got %b/%b expected 0010/0010", bus.o_c_rqa_rd, bus.o_c_rqd_rd); end
    tick();
    idle_all();
    #1;
    n_cmp++; if (bus.o_m_rqd_vld !== 1'b1 || bus.o_m_rqd !== sd) begin n_err++; $display("FAIL wait_out_d: got vld=%b %h expected vld=1 %h", bus.o_m_rqd_vld, bus.o_m_rqd, sd); end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] hold;
    int p;
    for (int k = 0; k < NCLI; k++) put_cli(k, 1'b1, 1'b1, 1'b0);
    set_up_rd(1'b1, 1'b1);
    tick();
    set_up_rd(1'b0, 1'b0);
    hold = m_a;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (bus.o_c_rqa_rd !== '0 || bus.o_c_rqd_rd !== '0) begin n_err++; $display("FAIL bp_client_rd[%0d]: got %b/%b expected 0/0", i, bus.o_c_rqa_rd, bus.o_c_rqd_rd); end
      n_cmp++; if (bus.o_m_rqa_vld !== 1'b1 || bus.o_m_rqa !== hold) begin n_err++; $display("FAIL bp_hold[%0d]: got vld=%b %h expected vld=1 %h", i, bus.o_m_rqa_vld, bus.o_m_rqa, hold); end
      tick();
    end
    set_up_rd(1'b1, 1'b1);
    #1;
    p = predict();
    n_cmp++; if (p < 0 || bus.o_c_rqa_rd !== onehot(p)) begin n_err++; $display("FAIL bp_release_grant: got %b expected %b", bus.o_c_rqa_rd, onehot(p)); end
    tick();
    #1;
    n_cmp++; if (bus.o_m_rqa_vld !== 1'b1 || bus.o_m_rqa !== m_a) begin n_err++; $display("FAIL bp_next_beat: got vld=%b %h expected vld=1 %h", bus.o_m_rqa_vld, bus.o_m_rqa, m_a); end
  endtask

  task automatic test_reset_midburst();
    int e;
    for (int k = 0; k < NCLI; k++) put_cli(k, 1'b1, 1'b1, 1'b0);
    set_up_rd(1'b1, 1'b1);
    tick(); tick();
    set_up_rd(1'b0, 1'b0);
    tick();
    #2; nrst = 1'b0; #1;
    n_cmp++; if (bus.o_m_rqa_vld !== 1'b0 || bus.o_m_rqd_vld !== 1'b0) begin n_err++; $display("FAIL midrst_vld: got %b/%b expected 0/0", bus.o_m_rqa_vld, bus.o_m_rqd_vld); end
    n_cmp++; if (bus.o_c_rqa_rd !== '0) begin n_err++; $display("FAIL midrst_client_rd: got %b expected 0", bus.o_c_rqa_rd); end
    model_reset();
    @(negedge clk);
    nrst = 1'b1;
    idle_all();
    put_cli(0, 1'b1, 1'b1, 1'b0);
    put_cli(1, 1'b1, 1'b1, 1'b0);
    set_up_rd(1'b1, 1'b1);
    // Clients 0 and 1 permanently eligible: alternate, or 8:1 with client-0 priority.
    for (int i = 0; i < 18; i++) begin
`ifdef VXE_AXI_SWITCH_ARB_QOS_EN
      e = (i % 9 == 8) ? 1 : 0;
`else
      e = i % 2;
`endif
      #1;
      n_cmp++; if (bus.o_c_rqa_rd !== onehot(e)) begin n_err++; $display("FAIL pair_grant[%0d]: got %b expected %b", i, bus.o_c_rqa_rd, onehot(e)); end
      tick();
    end
  endtask

  task automatic test_random();
    int p;
    logic [NCLI-1:0] ed;
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NCLI; k++)
        put_cli(k, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      set_up_rd($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      #1;
      p  = predict();
      ed = (p >= 0 && is_wr(p)) ? onehot(p) : '0;
      n_cmp++; if (bus.o_c_rqa_rd !== onehot(p)) begin n_err++; $display("FAIL rnd_rqa_rd[%0d]: got %b expected %b", n, bus.o_c_rqa_rd, onehot(p)); end
      n_cmp++; if (bus.o_c_rqd_rd !== ed) begin n_err++; $display("FAIL rnd_rqd_rd[%0d]: got %b expected %b", n, bus.o_c_rqd_rd, ed); end
      n_cmp++; if (bus.o_m_rqa_vld !== m_a_vld || bus.o_m_rqd_vld !== m_d_vld) begin n_err++; $display("FAIL rnd_vld[%0d]: got %b/%b expected %b/%b", n, bus.o_m_rqa_vld, bus.o_m_rqd_vld, m_a_vld, m_d_vld); end
      if (m_a_vld) begin
        n_cmp++; if (bus.o_m_rqa !== m_a) begin n_err++; $display("FAIL rnd_rqa[%0d]: got %h expected %h", n, bus.o_m_rqa, m_a); end
      end
      if (m_d_vld) begin
        n_cmp++; if (bus.o_m_rqd !== m_d) begin n_err++; $display("FAIL rnd_rqd[%0d]: got %h expected %h", n, bus.o_m_rqd, m_d); end
      end
      tick();
    end
    idle_all();
    set_up_rd(1'b1, 1'b1);
    tick(); tick(); tick();
    n_cmp++; if (act_a.size() != exp_a.size()) begin n_err++; $display("FAIL stream_a_count: got %0d expected %0d", act_a.size(), exp_a.size()); end
    n_cmp++; if (act_d.size() != exp_d.size()) begin n_err++; $display("FAIL stream_d_count: got %0d expected %0d", act_d.size(), exp_d.size()); end
    for (int i = 0; i < act_a.size() && i < exp_a.size(); i++) begin
      n_cmp++; if (act_a[i] !== exp_a[i]) begin n_err++; $display("FAIL stream_a[%0d]: got %h expected %h", i, act_a[i], exp_a[i]); end
    end
    for (int i = 0; i < act_d.size() && i < exp_d.size(); i++) begin
      n_cmp++; if (act_d[i] !== exp_d[i]) begin n_err++; $display("FAIL stream_d[%0d]: got %h expected %h", i, act_d[i], exp_d[i]); end
    end
  endtask

  initial begin
    nrst = 1'b0;
    set_up_rd(1'b1, 1'b1);
    idle_all();
    model_reset();
    test_reset();
    test_rr_reads();
    test_write();
    test_wait_data();
    test_backpressure();
    test_reset_midburst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
